// File: rtl/ahb_vga_ctrl.sv
// ahb_vga_ctrl: AHB-Lite slave with VGA timing, a posted write FIFO to the console engine
// and image buffer, and split-column layer compositing. Define AHB_VGA_READBACK_EN for register reads.
module ahb_vga_ctrl #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter int unsigned PIX_DIV    = 2,
    parameter int unsigned RGB_W      = 8,
    parameter int unsigned IMG_AW     = 14,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              HSEL,
    input  logic              HREADY,
    input  logic              HWRITE,
    input  logic [1:0]        HTRANS,
    input  logic [31:0]       HADDR,
    input  logic [31:0]       HWDATA,
    output logic [31:0]       HRDATA,
    output logic              HREADYOUT,
    output logic              HRESP,
    input  logic              console_busy,
    input  logic [RGB_W-1:0]  console_rgb,
    input  logic [RGB_W-1:0]  image_rgb,
    output logic              console_we,
    output logic [7:0]        console_wdata,
    output logic              image_we,
    output logic [IMG_AW-1:0] image_addr,
    output logic [RGB_W-1:0]  image_wdata,
    output logic [9:0]        pixel_x,
    output logic [9:0]        pixel_y,
    output logic              video_on,
    output logic              hsync,
    output logic              vsync,
    output logic [RGB_W-1:0]  rgb
);
    localparam int unsigned DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned DW    = (RGB_W > 8) ? RGB_W : 8;
    localparam int unsigned EW    = 1 + IMG_AW + DW;

    localparam logic [9:0] HA      = 10'(H_ACTIVE);
    localparam logic [9:0] HS_BEG  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END  = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] H_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] VA      = 10'(V_ACTIVE);
    localparam logic [9:0] VS_BEG  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END  = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] V_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    // AHB address-phase capture; haddr_q holds HADDR[23:2]
    logic        addr_valid_q, addr_valid_d;
    logic        hwrite_q, hwrite_d;
    logic [21:0] haddr_q, haddr_d;

    logic [9:0]  split_q, split_d;
    logic [2:0]  ctrl_q, ctrl_d;

    logic [EW-1:0]    mem_q [FIFO_DEPTH];
    logic [EW-1:0]    mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;

    logic              console_we_q, console_we_d;
    logic [7:0]        console_wdata_q, console_wdata_d;
    logic              image_we_q, image_we_d;
    logic [IMG_AW-1:0] image_addr_q, image_addr_d;
    logic [RGB_W-1:0]  image_wdata_q, image_wdata_d;

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       x_q, x_d, y_q, y_d;
    logic             video_on_q, video_on_d;
    logic             hsync_q, hsync_d, vsync_q, vsync_d;
    logic [RGB_W-1:0] rgb_q, rgb_d;

    logic          is_img, reg_space, wr_phase, fifo_wr, stall, push, pop, head_img;
    logic [1:0]    reg_off;
    logic [EW-1:0] entry, head;

    assign is_img    = haddr_q[21];
    assign reg_space = !haddr_q[21] && (haddr_q[20:2] == '0);
    assign reg_off   = haddr_q[1:0];
    assign wr_phase  = addr_valid_q && hwrite_q;
    assign fifo_wr   = wr_phase && (is_img || (reg_space && reg_off == 2'd0));
    assign stall     = fifo_wr && (level_q == LVL_FULL);
    assign push      = fifo_wr && !stall;
    assign head      = mem_q[rd_ptr_q];
    assign head_img  = head[EW-1];
    // In-order drain: a busy-blocked console head also holds back image entries behind it
    assign pop       = (level_q != '0) && (head_img || !console_busy);

    always_comb begin
        if (is_img)
            entry = {1'b1, haddr_q[IMG_AW-1:0], DW'(HWDATA[RGB_W-1:0])};
        else
            entry = {1'b0, {IMG_AW{1'b0}}, DW'(HWDATA[7:0])};
    end

    always_comb begin
        addr_valid_d = addr_valid_q;
        hwrite_d     = hwrite_q;
        haddr_d      = haddr_q;
        if (HREADY) begin
            addr_valid_d = HSEL && HTRANS[1];
            hwrite_d     = HWRITE;
            haddr_d      = HADDR[23:2];
        end

        split_d = split_q;
        ctrl_d  = ctrl_q;
        if (wr_phase && reg_space && reg_off == 2'd1) split_d = HWDATA[9:0];
        if (wr_phase && reg_space && reg_off == 2'd2) ctrl_d  = HWDATA[2:0];

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            mem_d[wr_ptr_q] = entry;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        console_we_d    = pop && !head_img;
        image_we_d      = pop && head_img;
        console_wdata_d = console_wdata_q;
        image_addr_d    = image_addr_q;
        image_wdata_d   = image_wdata_q;
        if (pop && !head_img) console_wdata_d = head[7:0];
        if (pop && head_img) begin
            image_addr_d  = head[DW +: IMG_AW];
            image_wdata_d = head[RGB_W-1:0];
        end
    end

    always_comb begin
        div_d = div_q + 1'b1;
        x_d   = x_q;
        y_d   = y_q;
        if (div_q == DIV_LAST) begin
            div_d = '0;
            if (x_q == H_LAST) begin
                x_d = '0;
                y_d = (y_q == V_LAST) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
        video_on_d = (x_d < HA) && (y_d < VA);
        hsync_d    = !((x_q >= HS_BEG) && (x_q < HS_END));
        vsync_d    = !((y_q >= VS_BEG) && (y_q < VS_END));
        rgb_d      = '0;
        if (video_on_q && !ctrl_q[2]) begin
            if (ctrl_q[0] && x_q < split_q) rgb_d = console_rgb;
            else if (ctrl_q[1])             rgb_d = image_rgb;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_valid_q    <= 1'b0;
            hwrite_q        <= 1'b0;
            haddr_q         <= '0;
            split_q         <= 10'd240;
            ctrl_q          <= 3'b011;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            level_q         <= '0;
            console_we_q    <= 1'b0;
            console_wdata_q <= '0;
            image_we_q      <= 1'b0;
            image_addr_q    <= '0;
            image_wdata_q   <= '0;
            div_q           <= '0;
            x_q             <= '0;
            y_q             <= '0;
            video_on_q      <= 1'b0;
            hsync_q         <= 1'b1;
            vsync_q         <= 1'b1;
            rgb_q           <= '0;
        end else begin
            addr_valid_q    <= addr_valid_d;
            hwrite_q        <= hwrite_d;
            haddr_q         <= haddr_d;
            split_q         <= split_d;
            ctrl_q          <= ctrl_d;
            mem_q           <= mem_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            level_q         <= level_d;
            console_we_q    <= console_we_d;
            console_wdata_q <= console_wdata_d;
            image_we_q      <= image_we_d;
            image_addr_q    <= image_addr_d;
            image_wdata_q   <= image_wdata_d;
            div_q           <= div_d;
            x_q             <= x_d;
            y_q             <= y_d;
            video_on_q      <= video_on_d;
            hsync_q         <= hsync_d;
            vsync_q         <= vsync_d;
            rgb_q           <= rgb_d;
        end
    end

`ifdef AHB_VGA_READBACK_EN
    logic vblank;
    assign vblank = y_q >= VA;

    always_comb begin
        HRDATA = '0;
        if (addr_valid_q && !hwrite_q && reg_space) begin
            case (reg_off)
                2'd1:    HRDATA = {22'b0, split_q};
                2'd2:    HRDATA = {29'b0, ctrl_q};
                2'd3:    HRDATA = {25'b0, vblank, console_busy, level_q == LVL_FULL, 4'(level_q)};
                default: HRDATA = '0;
            endcase
        end
    end
`else
    assign HRDATA = '0;
`endif

    logic unused;
    assign unused = &{1'b0, HADDR, HWDATA, HTRANS[0], head};

    assign HREADYOUT     = !stall;
    assign HRESP         = 1'b0;
    assign console_we    = console_we_q;
    assign console_wdata = console_wdata_q;
    assign image_we      = image_we_q;
    assign image_addr    = image_addr_q;
    assign image_wdata   = image_wdata_q;
    assign pixel_x       = x_q;
    assign pixel_y       = y_q;
    assign video_on      = video_on_q;
    assign hsync         = hsync_q;
    assign vsync         = vsync_q;
    assign rgb           = rgb_q;
endmodule
